// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling constants, sample points and the receiver/transmitter state enum.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned TICK_W     = 4;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned BIT_CNT_W  = 3;
  localparam int unsigned BAUD_CNT_W = 16;

  // Mid-cell sample points within the 16-tick bit cell; the bit is decided at SAMPLE_C.
  localparam logic [TICK_W-1:0] SAMPLE_A = 4'd7;
  localparam logic [TICK_W-1:0] SAMPLE_B = 4'd8;
  localparam logic [TICK_W-1:0] SAMPLE_C = 4'd9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator: one-clk tick every DIVIDER clocks, restartable by a synchronous clear.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned DIVIDER = 651
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam logic [BAUD_CNT_W-1:0] LAST = BAUD_CNT_W'(DIVIDER - 1);

  logic [BAUD_CNT_W-1:0] r_cnt;
  logic                  r_tick;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + BAUD_CNT_W'(1);
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling 8N1 UART receiver with valid/ready output and framing/overrun flags.
// Define UART_RX_PARITY_EN for 8-data + parity + stop framing with a parity_err pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 9600
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit          PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int unsigned DIVIDER = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);

  logic r_sync1, r_sync2, r_prev;
  logic w_fall, w_tick, w_decide, w_bit;

  uart_state_e r_state, w_state_next;
  logic        w_start, w_shift, w_deliver, w_frame_err;

  logic [TICK_W-1:0]    r_tick_cnt;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_samp_a, r_samp_b;

  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid, r_busy, r_frame_err, r_overrun;

`ifdef UART_RX_PARITY_EN
  logic r_parity_bit, r_parity_err;
  logic w_parity_err, w_par_latch, w_par_bad;
`endif

  // Two-flop synchroniser plus history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_fall   = r_prev & ~r_sync2;
  assign w_decide = w_tick && (r_tick_cnt == SAMPLE_C);
  assign w_bit    = majority3(r_samp_a, r_samp_b, r_sync2);

  uart_baud_gen #(
    .DIVIDER (DIVIDER)
  ) u_baud_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (w_start),
    .o_tick  (w_tick)
  );

`ifdef UART_RX_PARITY_EN
  assign w_par_bad = ((^r_shift) ^ r_parity_bit) != PARITY_ODD;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_shift      = 1'b0;
    w_deliver    = 1'b0;
    w_frame_err  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_parity_err = 1'b0;
    w_par_latch  = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_start      = 1'b1;
          w_state_next = START;
        end
      end
      START: begin
        if (w_decide) w_state_next = w_bit ? IDLE : DATA;
      end
      DATA: begin
        if (w_decide) begin
          w_shift = 1'b1;
          if (r_bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (w_decide) begin
          w_par_latch  = 1'b1;
          w_state_next = STOP;
        end
`else
        w_state_next = IDLE;
`endif
      end
      STOP: begin
        // A bad stop bit outranks a parity mismatch.
        if (w_decide) begin
          w_state_next = IDLE;
          if (!w_bit) begin
            w_frame_err = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (w_par_bad) begin
            w_parity_err = 1'b1;
`endif
          end else begin
            w_deliver = 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Bit-cell timing, mid-cell samples and the LSB-first shift register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_samp_a   <= 1'b0;
      r_samp_b   <= 1'b0;
    end else begin
      if (w_start)
        r_tick_cnt <= '0;
      else if (w_tick && (r_state != IDLE))
        r_tick_cnt <= r_tick_cnt + TICK_W'(1);

      if (w_tick && (r_tick_cnt == SAMPLE_A)) r_samp_a <= r_sync2;
      if (w_tick && (r_tick_cnt == SAMPLE_B)) r_samp_b <= r_sync2;

      if (w_start) begin
        r_bit_cnt <= '0;
      end else if (w_shift) begin
        r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
        r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_parity_bit <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_par_latch) r_parity_bit <= w_bit;
      r_parity_err <= w_parity_err;
    end
  end

  assign parity_err = r_parity_err;
`endif

  // Output handshake: a delivery into a held byte is dropped and flagged.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_busy      <= (w_state_next != IDLE);
      r_frame_err <= w_frame_err;
      r_overrun   <= 1'b0;
      if (w_deliver) begin
        if (!r_rx_valid || rx_ready) begin
          r_rx_data  <= r_shift;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun  <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign rx_busy   = r_busy;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule
